// File: rtl/keypad_seg_io.sv
// Keypad column scanner and six-digit multiplexed seven-segment driver on one prescaled tick.
// Optional key debounce is enabled with `define KEYPAD_DEBOUNCE_EN.
module keypad_seg_io #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_val,
  input  logic [5:0]  enables,
  input  logic [23:0] data,
  output logic [7:0]  seven_segs_point,
  output logic [5:0]  show_one
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    c_q, c_d;
  logic [2:0]    d_q, d_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    key_q, key_d;
  logic [5:0]    show_q, show_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick;
  logic          det;
  logic [1:0]    r_idx;
  logic [3:0]    code;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign tick = (pre_q == PW'(SCAN_DIV - 1));
  assign code = {r_idx, c_q};

  // Lowest-numbered low row wins when several keys share a column.
  always_comb begin
    det   = 1'b1;
    r_idx = 2'd0;
    if (!row[0])      r_idx = 2'd0;
    else if (!row[1]) r_idx = 2'd1;
    else if (!row[2]) r_idx = 2'd2;
    else if (!row[3]) r_idx = 2'd3;
    else              det   = 1'b0;
  end

  always_comb begin
    case (d_q)
      3'd0:    nib = data[3:0];
      3'd1:    nib = data[7:4];
      3'd2:    nib = data[11:8];
      3'd3:    nib = data[15:12];
      3'd4:    nib = data[19:16];
      default: nib = data[23:20];
    endcase
  end

  always_comb begin
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end

  // The digit shown after a tick is the one indexed before the tick advances d.
  always_comb begin
    pre_d  = tick ? '0 : pre_q + 1'b1;
    c_d    = c_q;
    d_d    = d_q;
    col_d  = col_q;
    show_d = show_q;
    seg_d  = seg_q;
    if (tick) begin
      c_d   = c_q + 2'd1;
      col_d = ~(4'b0001 << c_d);
      d_d   = (d_q == 3'd5) ? 3'd0 : d_q + 3'd1;
      if (enables[d_q]) begin
        show_d = ~(6'b00_0001 << d_q);
        seg_d  = {1'b1, glyph};
      end else begin
        show_d = 6'h3F;
        seg_d  = 8'hFF;
      end
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d;

  // hit tracks whether the current column 0..3 sweep saw any key at all.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    hit_d  = hit_q;
    key_d  = key_q;
    if (tick) begin
      if (det) begin
        hit_d = 1'b1;
        if (code == cand_q) begin
          if (cnt_q != CW'(DEBOUNCE_SCANS)) cnt_d = cnt_q + 1'b1;
        end else begin
          cand_d = code;
          cnt_d  = CW'(1);
        end
      end
      if (c_q == 2'd3) begin
        if (!hit_d) cnt_d = '0;
        hit_d = 1'b0;
      end
      if (cnt_d == CW'(DEBOUNCE_SCANS)) key_d = cand_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
    end
  end
`else
  always_comb begin
    key_d = key_q;
    if (tick && det) key_d = code;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q  <= '0;
      c_q    <= 2'd0;
      d_q    <= 3'd0;
      col_q  <= 4'b1110;
      key_q  <= 4'h0;
      show_q <= 6'h3F;
      seg_q  <= 8'hFF;
    end else begin
      pre_q  <= pre_d;
      c_q    <= c_d;
      d_q    <= d_d;
      col_q  <= col_d;
      key_q  <= key_d;
      show_q <= show_d;
      seg_q  <= seg_d;
    end
  end

  assign col              = col_q;
  assign key_val          = key_q;
  assign show_one         = show_q;
  assign seven_segs_point = seg_q;
endmodule

// File: tb/tb_keypad_seg_io.sv
// Bench for keypad_seg_io: tick-indexed reference model checked every cycle plus literal anchors.
module tb_keypad_seg_io;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_val;
  logic [5:0]  enables;
  logic [23:0] data;
  logic [7:0]  seven_segs_point;
  logic [5:0]  show_one;

  always #5 clk = ~clk;

  keypad_seg_io #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_val(key_val),
    .enables(enables), .data(data), .seven_segs_point(seven_segs_point),
    .show_one(show_one)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // row driver: static pattern, or a key that pulls press_row low only while press_col is driven
  logic       row_mode = 1'b0;
  logic [3:0] row_static = 4'hF;
  logic [3:0] press_col = 4'hF;
  logic [3:0] press_row = 4'hF;

  always @(negedge clk) begin
    if (row_mode) row = (col == press_col) ? press_row : 4'hF;
    else          row = row_static;
  end

  // reference model, indexed by the number of cycles since reset release
  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit         model_ok = 1'b0;
  int         cyc;
  logic [3:0] m_col, m_key;
  logic [5:0] m_show;
  logic [7:0] m_seg;
  int         cand, cnt, sweep_hits;

  always @(posedge clk) begin
    if (!rst) begin
      model_ok = 1'b1;
      cyc = 0; m_col = 4'hE; m_key = 4'h0; m_show = 6'h3F; m_seg = 8'hFF;
      cand = 0; cnt = 0; sweep_hits = 0;
    end else if (model_ok) begin
      if (cyc % SCAN_DIV == SCAN_DIV - 1) begin
        int n, cc, dd, code, nib;
        bit hit;
        n = cyc / SCAN_DIV;
        cc = n % 4;
        dd = n % 6;
        hit = 1'b0;
        code = 0;
        for (int r = 3; r >= 0; r--) if (!row[r]) begin hit = 1'b1; code = r * 4 + cc; end
`ifdef KEYPAD_DEBOUNCE_EN
        if (hit) begin
          sweep_hits++;
          if (code == cand) cnt = (cnt < DEB) ? cnt + 1 : cnt;
          else begin cand = code; cnt = 1; end
        end
        if (cc == 3) begin
          if (sweep_hits == 0) cnt = 0;
          sweep_hits = 0;
        end
        if (cnt == DEB) m_key = 4'(cand);
`else
        if (hit) m_key = 4'(code);
`endif
        m_col = ~(4'b0001 << ((n + 1) % 4));
        if (enables[dd]) begin
          nib = (int'(data) >> (4 * dd)) & 15;
          m_show = ~(6'b00_0001 << dd);
          m_seg = {1'b1, font_tab[nib]};
        end else begin
          m_show = 6'h3F;
          m_seg = 8'hFF;
        end
      end
      cyc++;
    end
  end

  // scoreboard: compare every cycle once the model has seen reset
  always @(negedge clk) begin
    if (model_ok) begin
      check("col", 32'(col), 32'(m_col));
      check("key_val", 32'(key_val), 32'(m_key));
      check("show_one", 32'(show_one), 32'(m_show));
      check("seg", 32'(seven_segs_point), 32'(m_seg));
    end
  end

  task automatic sync_digit0(input string name);
    int w = 0;
    while (show_one !== 6'h3E && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=show_one 3E within 40 cycles", name);
    end
  endtask

  logic [3:0] col_seq  [4] = '{4'hB, 4'h7, 4'hE, 4'hD};
  logic [5:0] disp_sh  [7] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
  logic [7:0] disp_sg  [7] = '{8'hF9, 8'h8E, 8'hC0, 8'hB0, 8'h88, 8'h92, 8'hF9};
  logic [5:0] blank_sh [6] = '{6'h3E, 6'h3F, 6'h3B, 6'h3F, 6'h3F, 6'h3F};
  logic [7:0] blank_sg [6] = '{8'hF9, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    rst = 1'b0; row = 4'hF; enables = 6'h3F; data = 24'h0;
    cycles(3);
    rst = 1'b1;
    check("rst_col", 32'(col), 32'h0E);
    check("rst_key", 32'(key_val), 32'h0);
    check("rst_show", 32'(show_one), 32'h3F);
    check("rst_seg", 32'(seven_segs_point), 32'hFF);
    cycles(4);
    check("tick1_col", 32'(col), 32'h0D);
    check("tick1_show", 32'(show_one), 32'h3E);
    check("tick1_seg", 32'(seven_segs_point), 32'hC0);

    for (int i = 0; i < 4; i++) begin
      cycles(4);
      check("walk_col", 32'(col), 32'(col_seq[i]));
    end
    check("walk_key", 32'(key_val), 32'h0);

    // key at row 2 / column 1, pressed while column 1 is being driven
    press_col = 4'b1101; press_row = 4'b1011; row_mode = 1'b1;
    cycles(4);
`ifndef KEYPAD_DEBOUNCE_EN
    check("press_key_first_tick", 32'(key_val), 32'h9);
`endif
    cycles(36);
    check("press_key_held", 32'(key_val), 32'h9);

    // rows 1 and 2 low on column 3: lowest row wins
    press_col = 4'b0111; press_row = 4'b1001;
    cycles(52);
    check("two_rows_key", 32'(key_val), 32'h7);
    row_mode = 1'b0; row_static = 4'hF;

    data = 24'h5A30F1; enables = 6'h3F;
    cycles(24);
    sync_digit0("disp_sync");
    for (int i = 0; i < 7; i++) begin
      check("disp_show", 32'(show_one), 32'(disp_sh[i]));
      check("disp_seg", 32'(seven_segs_point), 32'(disp_sg[i]));
      cycles(4);
    end

    enables = 6'b000101;
    cycles(24);
    sync_digit0("blank_sync");
    for (int i = 0; i < 6; i++) begin
      check("blank_show", 32'(show_one), 32'(blank_sh[i]));
      check("blank_seg", 32'(seven_segs_point), 32'(blank_sg[i]));
      cycles(4);
    end

    for (int it = 0; it < 250; it++) begin
      if (it == 120) begin
        rst = 1'b0;
        cycles($urandom_range(1, 3));
        rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        data = 24'($urandom);
        enables = 6'($urandom_range(0, 63));
      end
      case ($urandom_range(0, 2))
        0: begin row_mode = 1'b0; row_static = 4'hF; end
        1: begin row_mode = 1'b0; row_static = 4'($urandom_range(0, 15)); end
        default: begin
          press_col = ~(4'b0001 << $urandom_range(0, 3));
          press_row = ~(4'b0001 << $urandom_range(0, 3));
          row_mode = 1'b1;
        end
      endcase
      cycles($urandom_range(4, 48));
    end

    cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
